// File: rtl/pw_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : pw_conv_sched
// Purpose  : Sequencer for the 1x1 pointwise MAC of a depthwise-separable
//            block. Walks pixel -> out-channel -> in-channel loops (in-channel
//            fastest), issues 1-cycle-latency reads to the activation and
//            weight SRAMs, and emits a valid/ready beat stream carrying
//            activation, weight, bias, first/last-in-channel flags and oc_idx.
// Ports    : clk, rst_n (async, active low)
//            start / abort             - job control
//            cfg_in_ch, cfg_out_ch,
//            cfg_num_pix, cfg_act_base - job configuration, latched on start
//            busy / done               - job status
//            act_rd_*, wgt_rd_*        - SRAM read ports (1-cycle latency)
//            bias_rd_data              - bias returned alongside read data
//            pw_in_*                   - beat stream towards the MAC
//            oc_idx                    - output channel of the current beat
//            perf_stall_cnt            - only with PW_CONV_SCHED_PERF_EN
// Options  : PW_CONV_SCHED_PERF_EN - adds a saturating 32-bit stall counter
// Revision : 1.0 - initial release
// ============================================================================
module pw_conv_sched #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int MAX_IN_CH  = 1024,
    parameter int MAX_OUT_CH = 1024,
    parameter int MAX_PIX    = 12544,
    parameter int ACT_AW     = 24,
    parameter int WGT_AW     = 20
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [$clog2(MAX_IN_CH+1)-1:0]    cfg_in_ch,
    input  logic [$clog2(MAX_OUT_CH+1)-1:0]   cfg_out_ch,
    input  logic [$clog2(MAX_PIX+1)-1:0]      cfg_num_pix,
    input  logic [ACT_AW-1:0]                 cfg_act_base,
    output logic                              busy,
    output logic                              done,
    output logic                              act_rd_en,
    output logic [ACT_AW-1:0]                 act_rd_addr,
    input  logic [DATA_W-1:0]                 act_rd_data,
    output logic                              wgt_rd_en,
    output logic [WGT_AW-1:0]                 wgt_rd_addr,
    input  logic [DATA_W-1:0]                 wgt_rd_data,
    input  logic [ACC_W-1:0]                  bias_rd_data,
    output logic                              pw_in_valid,
    input  logic                              pw_in_ready,
    output logic [DATA_W-1:0]                 pw_in_data,
    output logic [DATA_W-1:0]                 pw_weight,
    output logic [ACC_W-1:0]                  pw_bias_acc,
    output logic                              pw_first_in_ch,
    output logic                              pw_last_in_ch,
    output logic [$clog2(MAX_OUT_CH)-1:0]     oc_idx
`ifdef PW_CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_stall_cnt
`endif
);

    localparam int c_ic_w  = $clog2(MAX_IN_CH + 1);
    localparam int c_oc_w  = $clog2(MAX_OUT_CH + 1);
    localparam int c_oci_w = $clog2(MAX_OUT_CH);
    localparam int c_pix_w = $clog2(MAX_PIX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched configuration (terminal counts kept pre-decremented)
    logic [c_ic_w-1:0]   r_in_ch;
    logic [c_ic_w-1:0]   r_in_ch_m1;
    logic [c_oc_w-1:0]   r_out_ch_m1;
    logic [c_pix_w-1:0]  r_num_pix_m1;

    // Loop counters and running addresses
    logic [c_ic_w-1:0]   r_ic;
    logic [c_oci_w-1:0]  r_oc;
    logic [c_pix_w-1:0]  r_pix;
    logic [ACT_AW-1:0]   r_act_addr;
    logic [ACT_AW-1:0]   r_pix_base;
    logic [WGT_AW-1:0]   r_wgt_addr;

    // Side-band of the read currently in flight (data returns next cycle)
    logic                r_inflight;
    logic                r_inf_first;
    logic                r_inf_last;
    logic [c_oci_w-1:0]  r_inf_oc;

    // 2-entry output FIFO
    logic [DATA_W-1:0]   r_fifo_data  [2];
    logic [DATA_W-1:0]   r_fifo_wgt   [2];
    logic [ACC_W-1:0]    r_fifo_bias  [2];
    logic                r_fifo_first [2];
    logic                r_fifo_last  [2];
    logic [c_oci_w-1:0]  r_fifo_oc    [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_start_acc;
    logic                w_cfg_zero;
    logic                w_valid;
    logic                w_pop;
    logic                w_pop_mem;
    logic                w_push;
    logic [2:0]          w_occ_after;
    logic                w_issue;
    logic                w_ic_wrap;
    logic                w_oc_wrap;
    logic                w_pix_wrap;
    logic                w_last_issue;
    logic                w_drained;

    logic [DATA_W-1:0]   w_head_data;
    logic [DATA_W-1:0]   w_head_wgt;
    logic [ACC_W-1:0]    w_head_bias;
    logic                w_head_first;
    logic                w_head_last;
    logic [c_oci_w-1:0]  w_head_oc;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_start_acc = (r_state == S_IDLE) && start && !abort;
    assign w_cfg_zero  = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_num_pix == '0);

    // The in-flight read counts as a visible FIFO entry: its data is
    // presented straight from the SRAM bus while nothing older is stored,
    // which gives the start -> read -> valid latency of two cycles.
    assign w_valid   = (r_count != 2'd0) || r_inflight;
    assign w_pop     = w_valid && pw_in_ready;
    assign w_pop_mem = w_pop && (r_count != 2'd0);
    assign w_push    = r_inflight && !(w_pop && (r_count == 2'd0));

    // Stored entries after this cycle; a new read only goes out if its data
    // is guaranteed a slot when it returns.
    assign w_occ_after = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_drained   = (w_occ_after == 3'd0);

    assign w_issue      = (r_state == S_RUN) && !abort && (w_occ_after < 3'd2);
    assign w_ic_wrap    = (r_ic == r_in_ch_m1);
    assign w_oc_wrap    = (c_oc_w'(r_oc) == r_out_ch_m1);
    assign w_pix_wrap   = (r_pix == r_num_pix_m1);
    assign w_last_issue = w_issue && w_ic_wrap && w_oc_wrap && w_pix_wrap;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_zero ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            done        = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Configuration latch, loop counters and running address adders
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ch      <= '0;
            r_in_ch_m1   <= '0;
            r_out_ch_m1  <= '0;
            r_num_pix_m1 <= '0;
            r_ic         <= '0;
            r_oc         <= '0;
            r_pix        <= '0;
            r_act_addr   <= '0;
            r_pix_base   <= '0;
            r_wgt_addr   <= '0;
        end else if (w_start_acc) begin
            r_in_ch      <= cfg_in_ch;
            r_in_ch_m1   <= cfg_in_ch - c_ic_w'(1);
            r_out_ch_m1  <= cfg_out_ch - c_oc_w'(1);
            r_num_pix_m1 <= cfg_num_pix - c_pix_w'(1);
            r_ic         <= '0;
            r_oc         <= '0;
            r_pix        <= '0;
            r_act_addr   <= cfg_act_base;
            r_pix_base   <= cfg_act_base;
            r_wgt_addr   <= '0;
        end else if (w_issue) begin
            if (!w_ic_wrap) begin
                r_ic       <= r_ic + c_ic_w'(1);
                r_act_addr <= r_act_addr + ACT_AW'(1);
                r_wgt_addr <= r_wgt_addr + WGT_AW'(1);
            end else begin
                r_ic <= '0;
                if (!w_oc_wrap) begin
                    // Weights for consecutive oc are contiguous, so the
                    // weight address simply keeps counting.
                    r_oc       <= r_oc + c_oci_w'(1);
                    r_act_addr <= r_pix_base;
                    r_wgt_addr <= r_wgt_addr + WGT_AW'(1);
                end else begin
                    r_oc       <= '0;
                    r_pix      <= r_pix + c_pix_w'(1);
                    r_pix_base <= r_pix_base + ACT_AW'(r_in_ch);
                    r_act_addr <= r_pix_base + ACT_AW'(r_in_ch);
                    r_wgt_addr <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // In-flight side-band: flags and oc travel one cycle behind the read
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_inf_first <= 1'b0;
            r_inf_last  <= 1'b0;
            r_inf_oc    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_first <= (r_ic == '0);
                r_inf_last  <= w_ic_wrap;
                r_inf_oc    <= r_oc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_wgt[i]   <= '0;
                r_fifo_bias[i]  <= '0;
                r_fifo_first[i] <= 1'b0;
                r_fifo_last[i]  <= 1'b0;
                r_fifo_oc[i]    <= '0;
            end
        end else if (abort) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= act_rd_data;
                r_fifo_wgt[r_wr_ptr]   <= wgt_rd_data;
                r_fifo_bias[r_wr_ptr]  <= bias_rd_data;
                r_fifo_first[r_wr_ptr] <= r_inf_first;
                r_fifo_last[r_wr_ptr]  <= r_inf_last;
                r_fifo_oc[r_wr_ptr]    <= r_inf_oc;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop_mem) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop_mem);
        end
    end

    // Head: oldest stored entry, else the read data arriving this cycle
    always_comb begin
        w_head_data  = act_rd_data;
        w_head_wgt   = wgt_rd_data;
        w_head_bias  = bias_rd_data;
        w_head_first = r_inf_first;
        w_head_last  = r_inf_last;
        w_head_oc    = r_inf_oc;
        if (r_count != 2'd0) begin
            w_head_data  = r_fifo_data[r_rd_ptr];
            w_head_wgt   = r_fifo_wgt[r_rd_ptr];
            w_head_bias  = r_fifo_bias[r_rd_ptr];
            w_head_first = r_fifo_first[r_rd_ptr];
            w_head_last  = r_fifo_last[r_rd_ptr];
            w_head_oc    = r_fifo_oc[r_rd_ptr];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (beat fields forced to zero whenever no beat is offered)
    // ------------------------------------------------------------------------
    assign act_rd_en      = w_issue;
    assign wgt_rd_en      = w_issue;
    assign act_rd_addr    = r_act_addr;
    assign wgt_rd_addr    = r_wgt_addr;

    assign pw_in_valid    = w_valid;
    assign pw_in_data     = w_valid ? w_head_data  : '0;
    assign pw_weight      = w_valid ? w_head_wgt   : '0;
    assign pw_bias_acc    = w_valid ? w_head_bias  : '0;
    assign pw_first_in_ch = w_valid && w_head_first;
    assign pw_last_in_ch  = w_valid && w_head_last;
    assign oc_idx         = w_valid ? w_head_oc    : '0;

`ifdef PW_CONV_SCHED_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
        end else if (w_start_acc) begin
            r_perf_stall <= '0;
        end else if (busy && w_valid && !pw_in_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pw_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_conv_sched
// Purpose  : Directed self-checking bench for pw_conv_sched. Small SRAM
//            models return address-derived data; expected beats are built
//            from the loop nest pixel -> oc -> ic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_conv_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [10:0] cfg_in_ch;
    logic [10:0] cfg_out_ch;
    logic [13:0] cfg_num_pix;
    logic [23:0] cfg_act_base;
    logic        busy;
    logic        done;
    logic        act_rd_en;
    logic [23:0] act_rd_addr;
    logic [7:0]  act_rd_data;
    logic        wgt_rd_en;
    logic [19:0] wgt_rd_addr;
    logic [7:0]  wgt_rd_data;
    logic [31:0] bias_rd_data;
    logic        pw_in_valid;
    logic        pw_in_ready;
    logic [7:0]  pw_in_data;
    logic [7:0]  pw_weight;
    logic [31:0] pw_bias_acc;
    logic        pw_first_in_ch;
    logic        pw_last_in_ch;
    logic [9:0]  oc_idx;
`ifdef PW_CONV_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    pw_conv_sched u_dut (
        .clk            (clk),
`ifdef PW_CONV_SCHED_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_in_ch      (cfg_in_ch),
        .cfg_out_ch     (cfg_out_ch),
        .cfg_num_pix    (cfg_num_pix),
        .cfg_act_base   (cfg_act_base),
        .busy           (busy),
        .done           (done),
        .act_rd_en      (act_rd_en),
        .act_rd_addr    (act_rd_addr),
        .act_rd_data    (act_rd_data),
        .wgt_rd_en      (wgt_rd_en),
        .wgt_rd_addr    (wgt_rd_addr),
        .wgt_rd_data    (wgt_rd_data),
        .bias_rd_data   (bias_rd_data),
        .pw_in_valid    (pw_in_valid),
        .pw_in_ready    (pw_in_ready),
        .pw_in_data     (pw_in_data),
        .pw_weight      (pw_weight),
        .pw_bias_acc    (pw_bias_acc),
        .pw_first_in_ch (pw_first_in_ch),
        .pw_last_in_ch  (pw_last_in_ch),
        .oc_idx         (oc_idx)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- SRAM models ----------------
    int cur_in_ch = 1;

    function automatic logic [7:0] act_f(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] wgt_f(input logic [19:0] w);
        logic [19:0] t;
        t = w * 20'd7 + 20'd3;
        return t[7:0];
    endfunction

    function automatic logic [31:0] bias_f(input int oc);
        return 32'hB000_0000 | 32'(oc);
    endfunction

    initial begin
        act_rd_data  = '0;
        wgt_rd_data  = '0;
        bias_rd_data = '0;
    end

    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_f(act_rd_addr);
        if (wgt_rd_en) begin
            wgt_rd_data  <= wgt_f(wgt_rd_addr);
            bias_rd_data <= bias_f(int'(wgt_rd_addr) / cur_in_ch);
        end
    end

    // ---------------- Monitor ----------------
    typedef struct {
        logic [7:0]  d;
        logic [7:0]  w;
        logic [31:0] b;
        logic        f;
        logic        l;
        logic [9:0]  oc;
        int          cyc;
    } beat_t;

    beat_t       beats[$];
    logic [23:0] act_addrs[$];
    logic [19:0] wgt_addrs[$];
    int          done_cycs[$];
    int          valid_cnt;
    int          stall_cnt;
    logic        prev_stall = 1'b0;
    beat_t       prev_head;

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", pw_in_valid, 1'b1);
                check_eq("hold_data",  pw_in_data, prev_head.d);
                check_eq("hold_wgt",   pw_weight, prev_head.w);
                check_eq("hold_bias",  pw_bias_acc, prev_head.b);
                check_eq("hold_flags", {pw_first_in_ch, pw_last_in_ch}, {prev_head.f, prev_head.l});
                check_eq("hold_oc",    oc_idx, prev_head.oc);
            end
            if (act_rd_en || wgt_rd_en) begin
                check_eq("rd_en_pair", wgt_rd_en, act_rd_en);
                act_addrs.push_back(act_rd_addr);
                wgt_addrs.push_back(wgt_rd_addr);
            end
            if (done) done_cycs.push_back(cyc);
            if (pw_in_valid) valid_cnt++;
            prev_head.d   = pw_in_data;
            prev_head.w   = pw_weight;
            prev_head.b   = pw_bias_acc;
            prev_head.f   = pw_first_in_ch;
            prev_head.l   = pw_last_in_ch;
            prev_head.oc  = oc_idx;
            prev_head.cyc = cyc;
            if (pw_in_valid && pw_in_ready) beats.push_back(prev_head);
            if (pw_in_valid && !pw_in_ready && busy) stall_cnt++;
            prev_stall = pw_in_valid && !pw_in_ready;
        end
    end

    task automatic clear_mon();
        beats.delete();
        act_addrs.delete();
        wgt_addrs.delete();
        done_cycs.delete();
        valid_cnt = 0;
        stall_cnt = 0;
    endtask

    // Caller is at posedge+1. Returns the cycle in which start was high.
    task automatic run_job(input int ic, input int oc, input int np, input logic [23:0] base,
                           input bit toggle, output int s_cyc);
        clear_mon();
        cur_in_ch    = (ic == 0) ? 1 : ic;
        cfg_in_ch    = 11'(ic);
        cfg_out_ch   = 11'(oc);
        cfg_num_pix  = 14'(np);
        cfg_act_base = base;
        pw_in_ready  = 1'b1;
        start        = 1'b1;
        s_cyc        = cyc;
        for (int t = 0; t < 300 && done_cycs.size() == 0; t++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            pw_in_ready = toggle ? ~pw_in_ready : 1'b1;
        end
        start = 1'b0;
        check_eq("done_seen", done_cycs.size() != 0, 1'b1);
        @(posedge clk); #1;
        pw_in_ready = 1'b1;
    endtask

    task automatic compare_beats(input int ic, input int oc, input int np, input logic [23:0] base);
        int idx = 0;
        int n   = ic * oc * np;
        check_eq("beat_count", beats.size(), n);
        check_eq("read_count", act_addrs.size(), n);
        for (int p = 0; p < np; p++) begin
            for (int o = 0; o < oc; o++) begin
                for (int i = 0; i < ic; i++) begin
                    logic [23:0] a;
                    logic [19:0] w;
                    a = base + 24'(p * ic + i);
                    w = 20'(o * ic + i);
                    if (idx < beats.size()) begin
                        check_eq($sformatf("b%0d_data", idx),  beats[idx].d,  act_f(a));
                        check_eq($sformatf("b%0d_wgt", idx),   beats[idx].w,  wgt_f(w));
                        check_eq($sformatf("b%0d_bias", idx),  beats[idx].b,  bias_f(o));
                        check_eq($sformatf("b%0d_first", idx), beats[idx].f,  i == 0);
                        check_eq($sformatf("b%0d_last", idx),  beats[idx].l,  i == ic - 1);
                        check_eq($sformatf("b%0d_oc", idx),    beats[idx].oc, 10'(o));
                    end
                    if (idx < act_addrs.size()) begin
                        check_eq($sformatf("r%0d_act_addr", idx), act_addrs[idx], a);
                        check_eq($sformatf("r%0d_wgt_addr", idx), wgt_addrs[idx], w);
                    end
                    idx++;
                end
            end
        end
        check_eq("done_count", done_cycs.size(), 1);
        if (beats.size() != 0 && done_cycs.size() != 0)
            check_eq("done_after_last", done_cycs[0] - beats[beats.size()-1].cyc, 1);
        check_eq("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        pw_in_ready  = 1'b1;
        cfg_in_ch    = '0;
        cfg_out_ch   = '0;
        cfg_num_pix  = '0;
        cfg_act_base = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_done",  done, 1'b0);
        check_eq("rst_valid", pw_in_valid, 1'b0);
        check_eq("rst_rd_en", {act_rd_en, wgt_rd_en}, 2'b00);
        check_eq("rst_addr",  {act_rd_addr, wgt_rd_addr}, 44'd0);
        check_eq("rst_data",  {pw_in_data, pw_weight, pw_bias_acc, oc_idx}, 58'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3x2x2, ready held high
        run_job(3, 2, 2, 24'h100, 1'b0, s);
        compare_beats(3, 2, 2, 24'h100);
        if (beats.size() >= 12) begin
            check_eq("first_valid_lat", beats[0].cyc - s, 2);
            check_eq("b4_hand_data", beats[4].d, 8'hA4);
            check_eq("b4_hand_wgt",  beats[4].w, 8'h1F);
            check_eq("b4_hand_bias", beats[4].b, 32'hB000_0001);
            check_eq("r6_hand_addr", act_addrs[6], 24'h103);
            check_eq("r11_hand_addr", act_addrs[11], 24'h105);
            check_eq("b11_flags", {beats[11].f, beats[11].l}, 2'b01);
            check_eq("throughput", beats[11].cyc - beats[0].cyc, 11);
        end

        // 3x2x2, ready toggling
        run_job(3, 2, 2, 24'h100, 1'b1, s);
        compare_beats(3, 2, 2, 24'h100);
        check_eq("stalls_seen", stall_cnt != 0, 1'b1);
`ifdef PW_CONV_SCHED_PERF_EN
        check_eq("perf_stall", perf_stall_cnt, 32'(stall_cnt));
`endif

        // in_ch=1, out_ch=4, one pixel
        run_job(1, 4, 1, 24'h040, 1'b0, s);
        compare_beats(1, 4, 1, 24'h040);

        // Zero out_ch; second start while busy must be ignored
        clear_mon();
        cfg_in_ch    = 11'd3;
        cfg_out_ch   = 11'd0;
        cfg_num_pix  = 14'd2;
        cfg_act_base = 24'h100;
        start        = 1'b1;
        s            = cyc;
        @(posedge clk); #1;
        check_eq("zero_busy", busy, 1'b1);
        cfg_out_ch = 11'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("zero_done_count", done_cycs.size(), 1);
        if (done_cycs.size() != 0) check_eq("zero_done_lat", done_cycs[0] - s, 2);
        check_eq("zero_reads", act_addrs.size(), 0);
        check_eq("zero_valid", valid_cnt, 0);
        check_eq("zero_idle", busy, 1'b0);

        // Abort after 5 beats, then a full job
        clear_mon();
        cur_in_ch    = 3;
        cfg_in_ch    = 11'd3;
        cfg_out_ch   = 11'd2;
        cfg_num_pix  = 14'd2;
        cfg_act_base = 24'h100;
        start        = 1'b1;
        for (int t = 0; t < 100 && beats.size() < 5; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("abort_pre_beats", beats.size(), 5);
        abort       = 1'b1;
        pw_in_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_valid", pw_in_valid, 1'b0);
        check_eq("abort_busy",  busy, 1'b0);
        check_eq("abort_rd_en", act_rd_en, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cycs.size(), 0);
        check_eq("abort_beats",   beats.size(), 5);
        run_job(3, 2, 2, 24'h100, 1'b0, s);
        compare_beats(3, 2, 2, 24'h100);

        // Async reset mid-run with the FIFO full
        clear_mon();
        cfg_in_ch    = 11'd3;
        cfg_out_ch   = 11'd2;
        cfg_num_pix  = 14'd2;
        cfg_act_base = 24'h100;
        pw_in_ready  = 1'b0;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check_eq("full_pre_valid", pw_in_valid, 1'b1);
        check_eq("full_pre_busy",  busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", pw_in_valid, 1'b0);
        check_eq("arst_busy",  busy, 1'b0);
        check_eq("arst_rd_en", act_rd_en, 1'b0);
        check_eq("arst_addr",  {act_rd_addr, wgt_rd_addr}, 44'd0);
        check_eq("arst_data",  {pw_in_data, pw_weight, pw_bias_acc, oc_idx,
                                pw_first_in_ch, pw_last_in_ch}, 60'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        pw_in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_busy",  busy, 1'b0);
        check_eq("post_rst_valid", pw_in_valid, 1'b0);
        check_eq("post_rst_beats", beats.size(), 0);
        run_job(1, 4, 1, 24'h200, 1'b0, s);
        compare_beats(1, 4, 1, 24'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
